// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter.
//   - arb_state_e  : arbiter FSM states (IDLE, BURST)
//   - DEF_*        : default values for the arbiter parameters
//   - WR_COUNT_W   : width of the saturating beat counter output
//   - BEAT_CNT_W   : width of the per-burst beat counter (MAX_BURST <= 15)
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;
    localparam int WR_COUNT_W     = 16;
    localparam int BEAT_CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin search: returns the first set bit of req,
// scanning upward from start and wrapping modulo N.
// Ports:
//   req   : request vector, one bit per requester
//   start : index where the search begins (highest priority)
//   found : high when any req bit is set
//   index : winning requester index (0 when nothing is found)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to start so the closest
    // requester (smallest distance from start) is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(start) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares a single FIFO write port between NUM_REQ requesters. A requester
// is chosen round-robin while idle, then holds the port for a burst of up
// to MAX_BURST beats. The burst ends early when the holder drops valid.
// FIFO full stalls the burst without ending it.
// Ports:
//   clk        : write-domain clock
//   rst_n      : synchronous active-low reset
//   req_valid  : per-requester data valid
//   req_data   : packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : per-requester accept (only the grant holder, only when not full)
//   full       : FIFO full flag
//   wr_en      : FIFO write enable
//   wr_data    : FIFO write data (payload of the grant holder)
//   grant_id   : current grant holder, 0 when idle
//   busy       : high while a burst is in progress
//   wr_count   : total beats written, saturating at all-ones
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [WR_COUNT_W-1:0]         wr_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);
    localparam logic [IDW-1:0]        LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [WR_COUNT_W-1:0] COUNT_MAX = '1;

    arb_state_e              state;
    logic [IDW-1:0]          grant;
    logic [IDW-1:0]          rr_ptr;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [WR_COUNT_W-1:0]   wr_count_q;
    logic                    pick_found;
    logic [IDW-1:0]          pick_idx;
    logic                    grant_valid;
    logic                    burst_done;
    logic [IDW-1:0]          next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign busy        = (state == BURST);
    assign grant_valid = req_valid[grant];
    assign grant_id    = grant;
    assign wr_count    = wr_count_q;

    // rst_n gates the handshake so nothing transfers during a reset cycle,
    // even though the registered state only clears at the following edge.
    assign wr_en = rst_n & busy & grant_valid & ~full;

    // The burst ends on the last allowed beat or as soon as the holder
    // drops valid; full on its own only stalls.
    assign burst_done = ~grant_valid | (wr_en & (beat_cnt == LAST_BEAT));
    assign next_ptr   = (grant == LAST_ID) ? '0 : grant + IDW'(1);

    // Only the grant holder sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (rst_n && busy) begin
            req_ready[grant] = ~full;
        end
    end

    // Payload mux follows the grant regardless of wr_en.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter FSM, round-robin pointer, beat counter and total beat count.
    // grant is cleared on leaving BURST so grant_id reads 0 while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_en && (wr_count_q != COUNT_MAX)) begin
                wr_count_q <= wr_count_q + WR_COUNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (burst_done) begin
                        state    <= IDLE;
                        grant    <= '0;
                        beat_cnt <= '0;
                        rr_ptr   <= next_ptr;
                    end else if (wr_en) begin
                        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
